// File: rtl/answer_tx_pkg.sv
// Shared types and defaults for the answer UART transmitter.
package answer_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DEFAULT_NUM_BYTES    = 30;
    localparam int UART_FRAME_BITS      = 10;

endpackage

// File: rtl/answer_uart_tx_if.sv
// Handshake and line signals between the answer packager and the UART transmitter.
interface answer_uart_tx_if #(
    parameter int NUM_BYTES = answer_tx_pkg::DEFAULT_NUM_BYTES
);
    import answer_tx_pkg::*;

    // start is taken on a rising edge where ready=1; ready then stays low
    // (busy high) until the edge that raises the one-cycle done pulse.
    logic                   start;
    logic [8*NUM_BYTES-1:0] answer_packaged;
    logic                   ready;
    logic                   busy;
    logic                   tx;
    logic                   done;
    state_t                 dbg_state;

    modport master (
        output start, answer_packaged,
        input  ready, busy, tx, done, dbg_state
    );

    modport slave (
        input  start, answer_packaged,
        output ready, busy, tx, done, dbg_state
    );

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serializer; a load on the final stop-bit cycle chains the next frame with no gap.
module uart_byte_tx
    import answer_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_last,
    output state_t     o_state
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]       r_bit, w_bit;
    logic [7:0]       r_shift, w_shift;
    logic             r_tx, w_tx;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = w_tick ? '0 : r_cnt + 1'b1;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_tx    = r_tx;
        case (r_state)
            IDLE: begin
                w_cnt = '0;
                w_tx  = 1'b1;
                if (i_load) begin
                    w_state = START_BIT;
                    w_shift = i_data;
                    w_tx    = 1'b0;
                end
            end
            START_BIT: begin
                if (w_tick) begin
                    w_state = DATA_BITS;
                    w_bit   = '0;
                    w_tx    = r_shift[0];
                end
            end
            DATA_BITS: begin
                if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        w_state = STOP_BIT;
                        w_tx    = 1'b1;
                    end else begin
                        // Shift register keeps the bit on the line at position 0.
                        w_bit   = r_bit + 3'd1;
                        w_shift = {1'b0, r_shift[7:1]};
                        w_tx    = r_shift[1];
                    end
                end
            end
            STOP_BIT: begin
                if (w_tick) begin
                    if (i_load) begin
                        w_state = START_BIT;
                        w_shift = i_data;
                        w_tx    = 1'b0;
                    end else begin
                        w_state = IDLE;
                        w_tx    = 1'b1;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign o_tx    = r_tx;
    assign o_busy  = (r_state != IDLE);
    assign o_last  = (r_state == STOP_BIT) && w_tick;
    assign o_state = r_state;

endmodule

// File: rtl/answer_uart_tx.sv
// Streams a packaged GA answer MSB-byte first over UART 8N1 and pulses done at the end.
// Optional checksum frame (byte sum mod 256) enabled by defining ANSWER_TX_CHECKSUM_EN.
module answer_uart_tx
    import answer_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_BYTES    = DEFAULT_NUM_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    answer_uart_tx_if.slave  bus
);

    localparam int MSG_W = 8 * NUM_BYTES;
`ifdef ANSWER_TX_CHECKSUM_EN
    localparam int NUM_FRAMES = NUM_BYTES + 1;
`else
    localparam int NUM_FRAMES = NUM_BYTES;
`endif
    localparam int IDX_W = $clog2(NUM_FRAMES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FRAMES - 1);

    logic             r_busy;
    logic             r_done;
    logic [IDX_W-1:0] r_idx;
    logic [MSG_W-1:0] r_buf;
`ifdef ANSWER_TX_CHECKSUM_EN
    logic [7:0]       r_sum;
`endif

    logic       w_accept, w_more, w_next, w_load;
    logic       w_tx, w_byte_busy, w_last;
    logic [7:0] w_byte;
    state_t     w_state;

    assign w_accept = bus.start && !r_busy && !w_byte_busy;
    assign w_more   = (r_idx != LAST_IDX);
    assign w_next   = r_busy && w_last && w_more;
    assign w_load   = w_accept || w_next;

    // Byte 0 goes straight from the input; later bytes come off the top of the shifted buffer.
    always_comb begin
        w_byte = r_buf[MSG_W-1 -: 8];
        if (!r_busy) begin
            w_byte = bus.answer_packaged[MSG_W-1 -: 8];
        end
`ifdef ANSWER_TX_CHECKSUM_EN
        else if (r_idx == LAST_IDX - 1'b1) begin
            w_byte = r_sum;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_idx  <= '0;
            r_buf  <= '0;
`ifdef ANSWER_TX_CHECKSUM_EN
            r_sum  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_busy <= 1'b1;
                r_idx  <= '0;
                r_buf  <= {bus.answer_packaged[MSG_W-9:0], 8'h00};
`ifdef ANSWER_TX_CHECKSUM_EN
                r_sum  <= bus.answer_packaged[MSG_W-1 -: 8];
`endif
            end else if (w_next) begin
                r_idx <= r_idx + 1'b1;
                r_buf <= {r_buf[MSG_W-9:0], 8'h00};
`ifdef ANSWER_TX_CHECKSUM_EN
                r_sum <= r_sum + r_buf[MSG_W-1 -: 8];
`endif
            end else if (r_busy && w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_byte),
        .o_tx    (w_tx),
        .o_busy  (w_byte_busy),
        .o_last  (w_last),
        .o_state (w_state)
    );

    assign bus.ready     = !r_busy;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.tx        = w_tx;
    assign bus.dbg_state = w_state;

endmodule

// File: doc/answer_uart_tx.md
# answer_uart_tx

Serializes a packaged 30-byte GA answer word onto a UART 8N1 line, most-significant byte first. Sits directly downstream of the answer packaging stage: it latches the 240-bit packaged answer on a start handshake, then streams 30 frames to the host PC. It reports completion with a one-cycle pulse so the GA controller can resume or load the next answer.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535.
- NUM_BYTES, default 30: bytes per answer; the answer port width is 8*NUM_BYTES.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to transmit; sampled only when ready=1.
- answer_packaged  in  240  packaged answer; byte k sits in [239-8k:232-8k], k=0 is sent first.
- ready  out  1  high when idle and able to accept start.
- busy  out  1  high while a message is being transmitted; always the inverse of ready.
- tx  out  1  UART line; idle high.
- done  out  1  one-cycle pulse when the final stop bit completes.

## Operation
- Reset values: tx=1, ready=1, busy=0, done=0. The FSM enters IDLE, and the byte and bit counters clear.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: when start=1 at an edge, latch answer_packaged into the shift buffer and clear the byte index. Go to START_BIT and deassert ready.
- START_BIT: tx=0 for CLKS_PER_BIT cycles, then go to DATA_BITS.
- DATA_BITS: send 8 bits, LSB first, CLKS_PER_BIT cycles each, then go to STOP_BIT.
- STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
  - If more bytes remain, increment the byte index and go to START_BIT. There is no idle gap between frames.
  - Otherwise pulse done, go to IDLE, and assert ready.
- start while busy is ignored. The latched buffer is not modified, and changes on answer_packaged during transmission have no effect.
- The bit-period counter is wide enough for CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Reset mid-operation: tx returns high immediately (asynchronously), the message is abandoned, no done pulse is issued, and the next start sends from byte 0.

## Timing
- start accepted at edge t: tx=0 from edge t through edge t+CLKS_PER_BIT.
- Bit j of byte k (j=0..7) occupies the interval beginning at edge t+(10k+1+j)*CLKS_PER_BIT.
- Final stop bit ends at edge t+10*NUM_BYTES*CLKS_PER_BIT (t+10*(NUM_BYTES+1)*CLKS_PER_BIT with checksum).
  - At that edge: done=1 for exactly one cycle, ready=1, busy=0.
- Earliest next accepted start: the following edge.
- tx is a registered output, so there are no glitches.

## Configuration
- ANSWER_TX_CHECKSUM_EN defined:
  - After the NUM_BYTES data bytes, one extra frame carries the sum of all data bytes mod 256.
  - The sum accumulates in an 8-bit register as bytes are loaded.
  - done is delayed until the checksum frame's stop bit completes.
- ANSWER_TX_CHECKSUM_EN undefined: exactly NUM_BYTES frames are sent and no accumulator is built.

## Structure
- Shared package answer_tx_pkg:
  - state enum (IDLE, START_BIT, DATA_BITS, STOP_BIT)
  - DEFAULT_CLKS_PER_BIT=868
  - DEFAULT_NUM_BYTES=30
  - UART_FRAME_BITS=10
- One sub-module: uart_byte_tx.
  - Serializes a single byte with its own load/busy handshake.
  - The top level handles byte sequencing, the checksum, and done.

## Test plan
All scenarios run with CLKS_PER_BIT=4.
- Reset, no start: tx=1, ready=1, busy=0, done=0; rst asserted mid-cycle forces tx=1 before the next edge.
- All-zero answer, start pulse at edge t: 30 frames, each 0 then 8x0 then 1; done high at exactly edge t+1200 for one cycle; ready=1 at the same edge.
- Bytes k=0..29 equal to 0x01..0x1E: the decoded UART stream is 0x01,0x02,...,0x1E in order; bit 0 of byte 0x01 is high in the first data-bit interval.
- start held high and answer_packaged changed during transmission: no restart, the original bytes are sent, and exactly one done pulse appears.
- rst asserted during byte 5, then new start: tx=1, ready=1, no done; the new message begins at byte 0 and completes 1200 cycles after acceptance.
- ANSWER_TX_CHECKSUM_EN with all bytes 0x1F: 31 frames, the last is 0xA2; done at edge t+1240.
